// File: rtl/mult_div_if.sv
// Start/Busy/Done handshake and HI/LO bus between the execute stage and the
// iterative multiply/divide unit.
interface mult_div_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  Start;
  logic [3:0]            MDOperation;
  logic [DATA_WIDTH-1:0] OperandA;
  logic [DATA_WIDTH-1:0] OperandB;
  logic                  HIWrite;
  logic                  LOWrite;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] HI;
  logic [DATA_WIDTH-1:0] LO;

  modport master (
    output Start, MDOperation, OperandA, OperandB, HIWrite, LOWrite, WriteData,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, MDOperation, OperandA, OperandB, HIWrite, LOWrite, WriteData,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU).
// Optional macro MDU_EARLY_TERM_EN: zero-operand operations skip the iteration phase.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mult_div_if.slave md
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx;
  logic [CW-1:0]   count_r;
  logic            div_r;
  logic            q_neg_r;
  logic            r_neg_r;
  logic            div_zero_r;
  logic            ovf_r;
  logic [W-1:0]    a_raw_r;
  logic [W-1:0]    mag_b_r;
  logic [2*W-1:0]  acc_r;
  logic [W-1:0]    hi_r;
  logic [W-1:0]    lo_r;
  logic            busy_r;
  logic            done_r;

  logic            start_ok_s;
  logic            op_div_s;
  logic            op_uns_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic [W-1:0]    mag_a_s;
  logic [W-1:0]    mag_b_s;
  logic            skip_s;
  logic [W:0]      add_s;
  logic [2*W-1:0]  mul_next_s;
  logic [W:0]      shift_s;
  logic [W:0]      diff_s;
  logic [2*W-1:0]  div_next_s;
  logic [2*W-1:0]  prod_s;
  logic [W-1:0]    quot_s;
  logic [W-1:0]    rem_s;
  logic [W-1:0]    res_hi_s;
  logic [W-1:0]    res_lo_s;

  // Only opcodes 4'b01xx belong to this unit; anything else leaves it idle.
  assign start_ok_s = md.Start && (md.MDOperation[3:2] == 2'b01);
  assign op_div_s   = md.MDOperation[1];
  assign op_uns_s   = md.MDOperation[0];
  assign a_neg_s    = !op_uns_s && md.OperandA[W-1];
  assign b_neg_s    = !op_uns_s && md.OperandB[W-1];
  assign mag_a_s    = a_neg_s ? -md.OperandA : md.OperandA;
  assign mag_b_s    = b_neg_s ? -md.OperandB : md.OperandB;

`ifdef MDU_EARLY_TERM_EN
  assign skip_s = (md.OperandA == '0) || (md.OperandB == '0);
`else
  assign skip_s = 1'b0;
`endif

  // Multiply: acc low half holds the multiplier, shifted out LSB first.
  assign add_s      = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, mag_b_r} : {(W+1){1'b0}});
  assign mul_next_s = {add_s, acc_r[W-1:1]};

  // Divide: acc high half is the partial remainder, low half the dividend/quotient.
  assign shift_s    = {acc_r[2*W-1:W], acc_r[W-1]};
  assign diff_s     = shift_s - {1'b0, mag_b_r};
  assign div_next_s = diff_s[W] ? {shift_s[W-1:0], acc_r[W-2:0], 1'b0}
                                : {diff_s[W-1:0],  acc_r[W-2:0], 1'b1};

  assign prod_s = q_neg_r ? -acc_r : acc_r;
  assign quot_s = q_neg_r ? -acc_r[W-1:0] : acc_r[W-1:0];
  assign rem_s  = r_neg_r ? -acc_r[2*W-1:W] : acc_r[2*W-1:W];

  // Final HI/LO selection including divide-by-zero and signed overflow.
  always_comb begin
    res_hi_s = '0;
    res_lo_s = '0;
    if (!div_r) begin
      res_hi_s = prod_s[2*W-1:W];
      res_lo_s = prod_s[W-1:0];
    end else if (div_zero_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = '1;
    end else if (ovf_r) begin
      res_hi_s = '0;
      res_lo_s = MOST_NEG;
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_nx = skip_s ? SIGN : CALC;
        else            state_nx = IDLE;
      end
      CALC: begin
        if (count_r == LAST_CNT) state_nx = SIGN;
        else                     state_nx = CALC;
      end
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Datapath, HI/LO and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= '0;
      div_r      <= 1'b0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
      ovf_r      <= 1'b0;
      a_raw_r    <= '0;
      mag_b_r    <= '0;
      acc_r      <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state_r == SIGN);
      busy_r <= (state_nx != IDLE);
      case (state_r)
        IDLE: begin
          if (md.HIWrite) hi_r <= md.WriteData;
          if (md.LOWrite) lo_r <= md.WriteData;
          if (start_ok_s) begin
            count_r    <= '0;
            div_r      <= op_div_s;
            q_neg_r    <= a_neg_s ^ b_neg_s;
            r_neg_r    <= a_neg_s;
            div_zero_r <= (md.OperandB == '0);
            ovf_r      <= !op_uns_s && (md.OperandA == MOST_NEG) && (md.OperandB == '1);
            a_raw_r    <= md.OperandA;
            mag_b_r    <= mag_b_s;
            acc_r      <= skip_s ? '0 : {{W{1'b0}}, mag_a_s};
          end
        end
        CALC: begin
          acc_r   <= div_r ? div_next_s : mul_next_s;
          count_r <= count_r + CW'(1);
        end
        SIGN: begin
          hi_r <= res_hi_s;
          lo_r <= res_lo_s;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  assign md.Busy = busy_r;
  assign md.Done = done_r;
  assign md.HI   = hi_r;
  assign md.LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected HI/LO and
// latency; a monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

`ifdef MDU_EARLY_TERM_EN
  localparam int LAT_ET = 1;
`else
  localparam int LAT_ET = 33;
`endif
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  exp_t sb_q[$];

  mult_div_if #(.DATA_WIDTH(32)) bus ();

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (bus.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got Done=1 expected no pending operation");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_hi", bus.HI, e.hi);
        chk("result_lo", bus.LO, e.lo);
        chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
        chk("busy_with_done", {31'b0, bus.Busy}, 32'd0);
      end
    end
  end

  // inj: busy-cycle count at which to disturb the unit; kind 0 = new Start, 1 = HIWrite.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                       input int inj, input int kind);
    exp_t        e;
    int          busy_n;
    bit          got;
    bit          injected;
    logic [31:0] hi_hold;
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOperation = op; bus.OperandA = a; bus.OperandB = b;
    e.hi = ehi; e.lo = elo; e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start_cyc = cyc;
    bus.Start = 1'b0;
    hi_hold = bus.HI;
    busy_n = 0; got = 1'b0; injected = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bus.Busy === 1'b1) busy_n++;
      if (injected) begin
        injected = 1'b0;
        bus.Start = 1'b0;
        bus.HIWrite = 1'b0;
        if (kind == 1) chk("hi_write_while_busy", bus.HI, hi_hold);
      end else if (busy_n == inj) begin
        injected = 1'b1;
        if (kind == 0) begin
          bus.Start = 1'b1; bus.MDOperation = 4'b0101;
          bus.OperandA = 32'd2; bus.OperandB = 32'd2;
        end else begin
          bus.HIWrite = 1'b1; bus.WriteData = 32'hDEADBEEF;
        end
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end
    chk("busy_cycles", 32'(busy_n), 32'(lat));
  endtask

  task automatic reg_write(input bit hw, input bit lw, input logic [31:0] d);
    @(negedge clk);
    bus.HIWrite = hw; bus.LOWrite = lw; bus.WriteData = d;
    @(posedge clk); #1;
    bus.HIWrite = 1'b0; bus.LOWrite = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0; bus.MDOperation = 4'b0000; bus.OperandA = 32'd0; bus.OperandB = 32'd0;
    bus.HIWrite = 1'b0; bus.LOWrite = 1'b0; bus.WriteData = 32'd0;
    repeat (2) @(posedge clk); #1;
    chk("reset_busy", {31'b0, bus.Busy}, 32'd0);
    chk("reset_done", {31'b0, bus.Done}, 32'd0);
    chk("reset_hi", bus.HI, 32'd0);
    chk("reset_lo", bus.LO, 32'd0);
    @(negedge clk) reset = 1'b1;

    do_op(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, LAT, -1, 0);
    do_op(4'b0100, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, LAT, -1, 0);
    do_op(4'b0111, 32'd100,      32'd7,        32'd2,        32'd14,       LAT, -1, 0);
    do_op(4'b0110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, LAT, -1, 0);
    do_op(4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, LAT, -1, 0);
    do_op(4'b0111, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, LAT_ET, -1, 0);
    do_op(4'b0110, 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF, LAT_ET, -1, 0);
    do_op(4'b0100, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, LAT, -1, 0);
    do_op(4'b0110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, LAT, -1, 0);
    do_op(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, LAT, -1, 0);
    do_op(4'b0101, 32'd0,        32'd5,        32'd0,        32'd0,        LAT_ET, -1, 0);
    do_op(4'b0111, 32'd0,        32'd5,        32'd0,        32'd0,        LAT_ET, -1, 0);
    // Second Start mid-calculation must be ignored.
    do_op(4'b0101, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, LAT, 5, 0);

    // Asynchronous reset mid-operation: immediate abort, no Done afterwards.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOperation = 4'b0101; bus.OperandA = 32'd5; bus.OperandB = 32'd5;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_abort", {31'b0, bus.Busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (40) @(posedge clk);

    do_op(4'b0101, 32'd3, 32'd4, 32'd0, 32'd12, LAT, -1, 0);

    reg_write(1'b1, 1'b0, 32'hCAFEF00D);
    chk("mthi_hi", bus.HI, 32'hCAFEF00D);
    chk("mthi_lo_kept", bus.LO, 32'd12);
    // HIWrite during CALC is dropped; the divide result then overwrites HI.
    do_op(4'b0111, 32'd100, 32'd7, 32'd2, 32'd14, LAT, 3, 1);
    reg_write(1'b1, 1'b1, 32'h55AA55AA);
    chk("mthilo_hi", bus.HI, 32'h55AA55AA);
    chk("mthilo_lo", bus.LO, 32'h55AA55AA);

    // Non-MDU opcode must not start anything.
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOperation = 4'b0011; bus.OperandA = 32'd9; bus.OperandB = 32'd9;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    chk("bad_op_busy", {31'b0, bus.Busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("bad_op_hi_kept", bus.HI, 32'h55AA55AA);
    chk("bad_op_lo_kept", bus.LO, 32'h55AA55AA);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
